// File: rtl/fp_addsub_sequencer.sv
// Multi-cycle binary32 add/subtract controller: capture, align, add/sub,
// normalize, round, then hold the result behind an output handshake.
module fp_addsub_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_overflow,
  output logic        flag_underflow,
  output logic        flag_invalid
);
  typedef enum logic [2:0] {IDLE, ALIGN, ADDSUB, NORM, ROUND, DONE} state_t;

  state_t             state;
  logic               sa, sb, spec, spec_inv, sign, sub, zero_n, unf_n;
  logic               ovf_q, unf_q, inv_q;
  logic [7:0]         ea, eb;
  logic [26:0]        ma, mb, man_big, man_small, man_n;
  logic [27:0]        sum;
  logic [31:0]        spec_res, res_q;
  logic signed [9:0]  exp_w;

  logic [31:0] bx, cap_res;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, cap_spec, cap_inv;
  logic        swap, lost, inc, fin_ovf, fin_unf, fin_inv;
  logic [7:0]  big_e, diff;
  logic [26:0] sml_m, shr, norm_m;
  logic [4:0]  lz;
  logic [24:0] rnd;
  logic signed [9:0] exp_l, exp_rnd;
  logic [31:0] fin_res;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

  // Special-operand decode on the raw inputs (subnormals count as zero)
  always_comb begin
    bx     = {b[31] ^ op, b[30:0]};
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    cap_spec = 1'b1;
    cap_inv  = 1'b0;
    cap_res  = 32'h7FC0_0000;
    if (a_nan || b_nan) begin
      cap_res = 32'h7FC0_0000;
    end else if (a_inf && b_inf && (a[31] != bx[31])) begin
      cap_inv = 1'b1;
    end else if (a_inf) begin
      cap_res = a;
    end else if (b_inf) begin
      cap_res = bx;
    end else if (a_zero && b_zero) begin
      cap_res = {a[31] & bx[31], 31'd0};
    end else begin
      cap_spec = 1'b0;
    end
  end

  // Alignment, normalization and rounding datapath
  always_comb begin
    swap  = {eb, mb} > {ea, ma};
    big_e = swap ? eb : ea;
    sml_m = swap ? ma : mb;
    diff  = swap ? (eb - ea) : (ea - eb);
    shr   = 27'd0;
    lost  = 1'b0;
    if (diff >= 8'd27) begin
      lost = |sml_m;
    end else begin
      shr  = sml_m >> diff;
      lost = |(sml_m & ((27'd1 << diff) - 27'd1));
    end
    lz      = lzc27(sum[26:0]);
    norm_m  = sum[26:0] << lz;
    exp_l   = exp_w - $signed({5'd0, lz});
    inc     = man_n[2] & (man_n[1] | man_n[0] | man_n[3]);
    rnd     = {1'b0, man_n[26:3]} + {24'd0, inc};
    exp_rnd = rnd[24] ? exp_w + 10'sd1 : exp_w;
    fin_ovf = 1'b0;
    fin_unf = 1'b0;
    fin_inv = 1'b0;
    if (spec) begin
      fin_res = spec_res;
      fin_inv = spec_inv;
    end else if (zero_n) begin
      fin_res = 32'd0;
    end else if (unf_n) begin
      fin_res = {sign, 31'd0};
      fin_unf = 1'b1;
    end else if (exp_rnd >= 10'sd255) begin
      fin_res = {sign, 8'hFF, 23'd0};
      fin_ovf = 1'b1;
    end else begin
      fin_res = {sign, exp_rnd[7:0], rnd[24] ? rnd[23:1] : rnd[22:0]};
    end
  end

  // Sequencer FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE; in_ready <= 1'b1; out_valid <= 1'b0; result <= 32'd0;
      flag_overflow <= 1'b0; flag_underflow <= 1'b0; flag_invalid <= 1'b0;
      sa <= 1'b0; sb <= 1'b0; ea <= 8'd0; eb <= 8'd0; ma <= 27'd0; mb <= 27'd0;
      spec <= 1'b0; spec_inv <= 1'b0; spec_res <= 32'd0; sign <= 1'b0; sub <= 1'b0;
      exp_w <= 10'sd0; man_big <= 27'd0; man_small <= 27'd0; sum <= 28'd0;
      man_n <= 27'd0; zero_n <= 1'b0; unf_n <= 1'b0;
      res_q <= 32'd0; ovf_q <= 1'b0; unf_q <= 1'b0; inv_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sa <= a[31]; sb <= bx[31];
            ea <= a[30:23]; eb <= bx[30:23];
            ma <= a_zero ? 27'd0 : {1'b1, a[22:0], 3'b000};
            mb <= b_zero ? 27'd0 : {1'b1, bx[22:0], 3'b000};
            spec <= cap_spec; spec_inv <= cap_inv; spec_res <= cap_res;
            flag_overflow <= 1'b0; flag_underflow <= 1'b0; flag_invalid <= 1'b0;
            in_ready <= 1'b0;
            state <= ALIGN;
          end else begin
            state <= IDLE;
          end
        end
        ALIGN: begin
          sign      <= swap ? sb : sa;
          sub       <= sa ^ sb;
          exp_w     <= $signed({2'd0, big_e});
          man_big   <= swap ? mb : ma;
          man_small <= {shr[26:1], shr[0] | lost};
          state     <= ADDSUB;
        end
        ADDSUB: begin
          sum   <= sub ? ({1'b0, man_big} - {1'b0, man_small})
                       : ({1'b0, man_big} + {1'b0, man_small});
          state <= NORM;
        end
        NORM: begin
          if (sum[27]) begin
            man_n <= {sum[27:2], sum[1] | sum[0]};
            exp_w <= exp_w + 10'sd1;
            zero_n <= 1'b0; unf_n <= 1'b0;
          end else if (lz == 5'd27) begin
            man_n <= 27'd0;
            zero_n <= 1'b1; unf_n <= 1'b0;
          end else begin
            man_n <= norm_m;
            exp_w <= exp_l;
            zero_n <= 1'b0; unf_n <= (exp_l <= 10'sd0);
          end
          state <= ROUND;
        end
        ROUND: begin
          res_q <= fin_res; ovf_q <= fin_ovf; unf_q <= fin_unf; inv_q <= fin_inv;
          state <= DONE;
        end
        DONE: begin
          // First DONE cycle loads the output register; later cycles wait for the consumer
          if (!out_valid) begin
            result <= res_q; flag_overflow <= ovf_q;
            flag_underflow <= unf_q; flag_invalid <= inv_q;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0; in_ready <= 1'b1; state <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state <= IDLE; in_ready <= 1'b1; out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_sequencer.sv
// Directed, table-driven bench for fp_addsub_sequencer.
module tb_fp_addsub_sequencer;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, op, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic        flag_overflow, flag_underflow, flag_invalid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic [2:0]  flags;  // {overflow, underflow, invalid}
  } vec_t;

  vec_t vecs[19];

  fp_addsub_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_overflow(flag_overflow),
    .flag_underflow(flag_underflow), .flag_invalid(flag_invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Capture one operation and return the number of clocks until out_valid
  task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                       input string name, output int lat);
    @(negedge clk);
    check({name, " in_ready"}, {63'd0, in_ready}, 64'd1);
    a = va; b = vb; op = vop; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; op = ~vop;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check({name, " latency"}, 64'(lat), 64'd5);
  endtask

  task automatic handshake(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({name, " released"}, {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 3'b000};
    vecs[1]  = '{32'h3FC0_0000, 32'h3FA0_0000, 1'b1, 32'h3E80_0000, 3'b000};
    vecs[2]  = '{32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 3'b000};
    vecs[3]  = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3'b100};
    vecs[4]  = '{32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 3'b001};
    vecs[5]  = '{32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 3'b000};
    vecs[6]  = '{32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, 3'b000};
    vecs[7]  = '{32'h3F80_0000, 32'h3380_0001, 1'b0, 32'h3F80_0001, 3'b000};
    vecs[8]  = '{32'h4000_0000, 32'hC040_0000, 1'b0, 32'hBF80_0000, 3'b000};
    vecs[9]  = '{32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 3'b000};
    vecs[10] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 3'b000};
    vecs[11] = '{32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, 3'b000};
    vecs[12] = '{32'h4040_0000, 32'h7F80_0000, 1'b0, 32'h7F80_0000, 3'b000};
    vecs[13] = '{32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000, 3'b010};
    vecs[14] = '{32'h7F7F_FFFF, 32'h7300_0000, 1'b0, 32'h7F80_0000, 3'b100};
    vecs[15] = '{32'h0000_0001, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 3'b000};
    vecs[16] = '{32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 3'b001};
    vecs[17] = '{32'h3F80_0000, 32'h2F80_0000, 1'b0, 32'h3F80_0000, 3'b000};
    vecs[18] = '{32'h0000_0000, 32'h8000_0001, 1'b0, 32'h0000_0000, 3'b000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 32'd0; b = 32'd0; op = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset state", {28'd0, in_ready, out_valid, result, flag_overflow,
          flag_underflow, flag_invalid}, {28'd0, 1'b1, 1'b0, 32'd0, 3'b000});
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      issue(vecs[i].a, vecs[i].b, vecs[i].op, nm, lat);
      check({nm, " result"}, {32'd0, result}, {32'd0, vecs[i].res});
      check({nm, " flags"}, {61'd0, flag_overflow, flag_underflow, flag_invalid},
            {61'd0, vecs[i].flags});
      handshake(nm);
    end

    // Backpressure: early out_ready is ignored, then a 10-cycle stall
    @(negedge clk);
    a = 32'h3F80_0000; b = 32'h3F80_0000; op = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    lat = 2;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check("hold latency", 64'(lat), 64'd5);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; a = 32'h4000_0000; b = 32'h4040_0000;
      @(posedge clk);
      #1;
      check($sformatf("hold cycle %0d", c), {30'd0, out_valid, in_ready, result},
            {30'd0, 1'b1, 1'b0, 32'h4000_0000});
    end
    in_valid = 1'b0;
    handshake("hold");

    // Reset while the operation sits in NORM
    @(negedge clk);
    a = 32'h3FC0_0000; b = 32'h3FA0_0000; op = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rst async", {62'd0, out_valid, in_ready}, 64'b01);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check("rst after", {62'd0, out_valid, in_ready}, 64'b01);
    repeat (6) begin
      @(posedge clk);
      #1 check("rst no result", {63'd0, out_valid}, 64'd0);
    end

    issue(32'h3FC0_0000, 32'h3FA0_0000, 1'b1, "post rst", lat);
    check("post rst result", {32'd0, result}, {32'd0, 32'h3E80_0000});
    handshake("post rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
